// File: rtl/sym_vn_lut_in.sv
// Write-side loader for the symmetric VN LUT rank memory: pairs a stream of
// LUT entries into bank0/bank1 words and drives one write-port cycle per page.
module sym_vn_lut_in #(
    parameter int PAGE_NUM    = 64,
    parameter int QUAN_SIZE   = 4,
    parameter int PAGE_ADDR_W = 6
) (
    input  logic                   write_clk,
    input  logic                   rstn,
    input  logic                   load_start,
    input  logic                   load_offset,
    input  logic                   load_abort,
    input  logic [QUAN_SIZE-1:0]   din,
    input  logic                   din_valid,
    output logic                   din_ready,
    output logic [QUAN_SIZE-1:0]   lut_in_bank0,
    output logic [QUAN_SIZE-1:0]   lut_in_bank1,
    output logic [PAGE_ADDR_W-1:0] page_write_addr,
    output logic                   write_addr_offset,
    output logic                   we,
    output logic                   load_busy,
    output logic                   load_done
);

    typedef enum logic [2:0] {IDLE, FILL0, FILL1, WR, DONE} state_e;

    localparam logic [PAGE_ADDR_W-1:0] LAST_PAGE = PAGE_ADDR_W'(PAGE_NUM - 1);

    state_e                 state_q, state_d;
    logic [PAGE_ADDR_W-1:0] page_cnt_q, page_cnt_d;
    logic [QUAN_SIZE-1:0]   hold_q;
    logic [QUAN_SIZE-1:0]   bank0_q, bank1_q;
    logic [PAGE_ADDR_W-1:0] addr_q;
    logic                   off_q;

    always_ff @(posedge write_clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            page_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            page_cnt_q <= page_cnt_d;
        end
    end

    // Abort has priority over every handshake and over a same-cycle start.
    always_comb begin
        state_d    = state_q;
        page_cnt_d = page_cnt_q;
        case (state_q)
            IDLE: begin
                if (load_start && !load_abort) begin
                    state_d    = FILL0;
                    page_cnt_d = '0;
                end
            end
            FILL0: begin
                if (load_abort)     state_d = IDLE;
                else if (din_valid) state_d = FILL1;
            end
            FILL1: begin
                if (load_abort)     state_d = IDLE;
                else if (din_valid) state_d = WR;
            end
            WR: begin
                if (load_abort) begin
                    state_d = IDLE;
                end else if (page_cnt_q == LAST_PAGE) begin
                    state_d = DONE;
                end else begin
                    state_d    = FILL0;
                    page_cnt_d = page_cnt_q + PAGE_ADDR_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake-facing outputs decode registered state only.
    always_comb begin
        din_ready = (state_q == FILL0) || (state_q == FILL1);
        we        = (state_q == WR);
        load_busy = (state_q != IDLE);
        load_done = (state_q == DONE);
    end

    always_ff @(posedge write_clk or negedge rstn) begin
        if (!rstn) begin
            hold_q  <= '0;
            bank0_q <= '0;
            bank1_q <= '0;
            addr_q  <= '0;
            off_q   <= 1'b0;
        end else begin
            if (state_q == IDLE && load_start && !load_abort)
                off_q <= load_offset;
            if (state_q == FILL0 && din_valid && !load_abort)
                hold_q <= din;
            if (state_q == FILL1 && din_valid && !load_abort) begin
                bank0_q <= hold_q;
                bank1_q <= din;
                addr_q  <= page_cnt_q;
            end
        end
    end

    assign lut_in_bank0      = bank0_q;
    assign lut_in_bank1      = bank1_q;
    assign page_write_addr   = addr_q;
    assign write_addr_offset = off_q;

endmodule

// File: tb/tb_sym_vn_lut_in.sv
// Bench for sym_vn_lut_in: a page-schedule model predicts every output each
// cycle; directed loads cover full, stalled, aborted and reset-interrupted runs.
module tb_sym_vn_lut_in;

    localparam int PAGE_NUM = 64;

    logic       write_clk = 1'b0;
    logic       rstn = 1'b0;
    logic       load_start = 1'b0, load_offset = 1'b0, load_abort = 1'b0;
    logic [3:0] din = '0;
    logic       din_valid = 1'b0;
    logic       din_ready, we, load_busy, load_done, write_addr_offset;
    logic [3:0] lut_in_bank0, lut_in_bank1;
    logic [5:0] page_write_addr;

    sym_vn_lut_in #(.PAGE_NUM(PAGE_NUM), .QUAN_SIZE(4), .PAGE_ADDR_W(6)) dut (
        .write_clk(write_clk), .rstn(rstn), .load_start(load_start),
        .load_offset(load_offset), .load_abort(load_abort), .din(din),
        .din_valid(din_valid), .din_ready(din_ready), .lut_in_bank0(lut_in_bank0),
        .lut_in_bank1(lut_in_bank1), .page_write_addr(page_write_addr),
        .write_addr_offset(write_addr_offset), .we(we), .load_busy(load_busy),
        .load_done(load_done)
    );

    always #5 write_clk = ~write_clk;

    int nvec = 0, nerr = 0;
    int cyc = 0;
    bit active = 0;
    int e0 = 0, cur_off = 0;
    int stall_pg = -1, stall_len = 0, abort_rel = -1;
    int we_cnt = 0, done_cnt = 0, done_rel = -1;
    logic [3:0] eb0 = '0, eb1 = '0;
    logic [5:0] eaddr = '0;
    logic       eoff = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_we"}, we, 0);
        chk({tag, "_ready"}, din_ready, 0);
        chk({tag, "_busy"}, load_busy, 0);
        chk({tag, "_done"}, load_done, 0);
        chk({tag, "_b0"}, lut_in_bank0, 0);
        chk({tag, "_b1"}, lut_in_bank1, 0);
        chk({tag, "_addr"}, page_write_addr, 0);
        chk({tag, "_off"}, write_addr_offset, 0);
    endtask

    // Schedule after edge r of a load (E0 = edge 0): page p takes its bank0
    // entry at 3p+1 and bank1 at 3p+2, shifted by any stall inserted before
    // bank1 of stall_pg. st: 0 idle, 1 fill0, 2 fill1, 3 write, 4 done.
    function automatic void phase(input int r, output int st, output int pg);
        int b0, b1;
        st = 0; pg = 0; b1 = 0;
        if (abort_rel >= 0 && r >= abort_rel) return;
        for (int p = 0; p < PAGE_NUM; p++) begin
            b0 = 3*p + 1 + ((stall_pg >= 0 && p >  stall_pg) ? stall_len : 0);
            b1 = 3*p + 2 + ((stall_pg >= 0 && p >= stall_pg) ? stall_len : 0);
            pg = p;
            if (r < b0)  begin st = 1; return; end
            if (r < b1)  begin st = 2; return; end
            if (r == b1) begin st = 3; return; end
        end
        pg = 0;
        if (r == b1 + 1) st = 4;
    endfunction

    initial begin
        int st, pg, rel;
        forever begin
            @(posedge write_clk);
            #1;
            cyc++;
            if (!rstn) begin
                eb0 = '0; eb1 = '0; eaddr = '0; eoff = 1'b0;
                chk_zero("rst");
            end else begin
                rel = cyc - e0;
                st = 0; pg = 0;
                if (active && rel >= 0) phase(rel, st, pg);
                if (active && rel == 0) eoff = cur_off[0];
                if (st == 3) begin
                    eb0 = 4'((2*pg) % 16);
                    eb1 = 4'((2*pg + 1) % 16);
                    eaddr = 6'(pg);
                end
                chk("we", we, int'(st == 3));
                chk("din_ready", din_ready, int'(st == 1 || st == 2));
                chk("load_busy", load_busy, int'(st != 0));
                chk("load_done", load_done, int'(st == 4));
                chk("bank0", lut_in_bank0, eb0);
                chk("bank1", lut_in_bank1, eb1);
                chk("page_addr", page_write_addr, eaddr);
                chk("offset", write_addr_offset, eoff);
                if (we) we_cnt++;
                if (load_done) begin done_cnt++; done_rel = rel; end
            end
        end
    end

    // Entries are i mod 16. Optional: stall after stall_ent, abort right
    // after abort_ent is taken, stray start at ign_ent, reset after rst_ent.
    task automatic run_load(input bit off, input int stall_ent, input int slen,
                            input int abort_ent, input int ign_ent, input int rst_ent);
        int t;
        we_cnt = 0; done_cnt = 0; done_rel = -1;
        stall_pg  = (stall_ent >= 0) ? stall_ent / 2 : -1;
        stall_len = slen;
        abort_rel = (abort_ent >= 0) ? 3*(abort_ent / 2) + 2 : -1;
        cur_off = int'(off); e0 = cyc + 1; active = 1;
        load_start = 1'b1; load_offset = off;
        @(negedge write_clk);
        load_start = 1'b0;
        for (int i = 0; i < 2*PAGE_NUM; i++) begin
            din = 4'(i); din_valid = 1'b1;
            if (i == ign_ent) begin load_start = 1'b1; load_offset = 1'b0; end
            t = 0;
            while (!din_ready && t < 20) begin @(negedge write_clk); t++; end
            if (!din_ready) begin
                nvec++; nerr++;
                $display("FAIL ready_timeout: entry %0d never accepted", i);
                break;
            end
            @(negedge write_clk);
            load_start = 1'b0;
            if (i == abort_ent) begin
                din_valid = 1'b0; load_abort = 1'b1;
                @(negedge write_clk);
                load_abort = 1'b0;
                break;
            end
            if (i == rst_ent) begin
                chk("pre_rst_we", we, 1);
                rstn = 1'b0; active = 0;
                #1;
                chk_zero("async_rst");
                repeat (2) @(negedge write_clk);
                din_valid = 1'b0;
                rstn = 1'b1;
                break;
            end
            if (i == stall_ent) begin
                din_valid = 1'b0;
                repeat (slen) @(negedge write_clk);
            end
        end
        din_valid = 1'b0;
        repeat (2) @(negedge write_clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with random inputs.
        for (int k = 0; k < 3; k++) begin
            @(negedge write_clk);
            din = 4'($urandom); din_valid = 1'($urandom);
            load_start = 1'($urandom); load_offset = 1'($urandom);
            load_abort = 1'($urandom);
            #1;
            chk_zero("in_rst");
        end
        @(negedge write_clk);
        din = '0; din_valid = 1'b0; load_start = 1'b0; load_offset = 1'b0; load_abort = 1'b0;
        rstn = 1'b1;
        repeat (3) @(negedge write_clk);

        // Start and abort together: abort wins.
        load_start = 1'b1; load_offset = 1'b1; load_abort = 1'b1;
        @(negedge write_clk);
        load_start = 1'b0; load_abort = 1'b0;
        repeat (2) @(negedge write_clk);
        chk("start_abort_busy", load_busy, 0);
        chk("start_abort_off", write_addr_offset, 0);

        // Full load, offset 1.
        run_load(1'b1, -1, 0, -1, -1, -1);
        chk("full_we_cnt", we_cnt, 64);
        chk("full_done_cnt", done_cnt, 1);
        chk("full_done_edge", done_rel, 192);

        // Five-cycle stall between bank0 and bank1 of page 3.
        run_load(1'b1, 6, 5, -1, -1, -1);
        chk("stall_we_cnt", we_cnt, 64);
        chk("stall_done_edge", done_rel, 197);

        // Abort in FILL1 of page 10.
        run_load(1'b0, -1, 0, 20, -1, -1);
        repeat (5) @(negedge write_clk);
        chk("abort_we_cnt", we_cnt, 10);
        chk("abort_done_cnt", done_cnt, 0);
        chk("abort_last_addr", page_write_addr, 9);

        // Stray start with offset 0 during an offset-1 load.
        run_load(1'b1, -1, 0, -1, 40, -1);
        chk("ign_we_cnt", we_cnt, 64);
        chk("ign_done_edge", done_rel, 192);
        chk("ign_offset", write_addr_offset, 1);

        // Reset while page 20 is being written, then a clean load.
        run_load(1'b1, -1, 0, -1, -1, 41);
        chk("rst_we_cnt", we_cnt, 21);
        run_load(1'b0, -1, 0, -1, -1, -1);
        chk("post_rst_we_cnt", we_cnt, 64);
        chk("post_rst_done_edge", done_rel, 192);
        chk("post_rst_last_addr", page_write_addr, 63);

        repeat (3) @(negedge write_clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
